counter_ud_param: RTL and testbench

COUNTER_UD_PARAM -- requirements
Module: counter_ud_param

---
 rtl/counter_pkg.sv | 16 +
 rtl/counter_prescaler.sv | 42 ++++
 rtl/counter_ud_param.sv | 103 ++++++++++
 tb/tb_counter_ud_param.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the up/down counter: limit-handling modes and the
// sizing helper for the prescaler phase register.
package counter_pkg;

   // Behaviour of the counter when a step is attempted beyond a limit.
   typedef enum logic {
      MODE_WRAP = 1'b0,   // roll over to the opposite limit
      MODE_SAT  = 1'b1    // hold at the limit
   } limit_mode_e;

   // Bits needed to hold a prescaler phase in 0..prescale-1 (at least 1).
   function automatic int unsigned presc_width(input int unsigned prescale);
      return (prescale <= 2) ? 1 : $clog2(prescale);
   endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Divides the enabled-cycle stream down to one tick every PRESCALE enabled
// cycles. The phase only advances while en is high; restart forces it to 0.
module counter_prescaler
   import counter_pkg::*;
#(
   parameter int unsigned PRESCALE = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic restart,
   output logic tick
);

   generate
      if (PRESCALE == 1) begin : g_direct
         // Every enabled cycle is a tick, so no phase state is needed.
         logic unused_ok;
         assign unused_ok = &{1'b0, clk, rst, restart};
         assign tick      = en;
      end else begin : g_count
         localparam int unsigned   PW   = presc_width(PRESCALE);
         localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

         logic [PW-1:0] phase;

         assign tick = en && (phase == LAST);

         // Phase counter: 0..PRESCALE-1, frozen while en is low.
         // NOTE: state registers use non-blocking assignments so every flop
         // samples the pre-edge value of its inputs.
         always_ff @(posedge clk) begin
            if (rst || restart) begin
               phase <= '0;
            end else if (en) begin
               phase <= (phase == LAST) ? '0 : phase + PW'(1);
            end
         end
      end
   endgenerate

endmodule

// File: rtl/counter_ud_param.sv
// Parameterised up/down counter with terminal count MAX_VAL, optional
// prescaling, wrap-or-saturate limit handling, a one-cycle terminal pulse and
// sticky overflow/underflow flags.
module counter_ud_param
   import counter_pkg::*;
#(
   parameter int unsigned      WIDTH    = 7,
   parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
   parameter int unsigned      PRESCALE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             inc,
   input  logic             dec,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             sat_mode,
   input  logic             clr_flags,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             zero,
   output logic             ovf,
   output logic             unf
);

   limit_mode_e      mode;
   logic             tick;
   logic             step_up;
   logic             step_dn;
   logic [WIDTH-1:0] load_clamped;
   logic [WIDTH-1:0] count_nxt;
   logic             tc_nxt;
   logic             ovf_hit;
   logic             unf_hit;

   assign mode = limit_mode_e'(sat_mode);

   // A load also realigns the prescaler so the next step is a full period away.
   counter_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .restart (load),
      .tick    (tick)
   );

   // Conflicting inc/dec requests cancel; load always takes precedence.
   assign step_up = tick && !load && inc && !dec;
   assign step_dn = tick && !load && dec && !inc;

   // Loaded values above the terminal count are clipped to it.
   assign load_clamped = (load_val > MAX_VAL) ? MAX_VAL : load_val;

   // Next count, terminal pulse and limit events for this cycle.
   // NOTE: every output of this block gets a default first, so no path can
   // leave a value unassigned and infer a latch.
   always_comb begin
      count_nxt = count;
      tc_nxt    = 1'b0;
      ovf_hit   = 1'b0;
      unf_hit   = 1'b0;
      if (load) begin
         count_nxt = load_clamped;
      end else if (step_up) begin
         if (count == MAX_VAL) begin
            ovf_hit   = 1'b1;
            tc_nxt    = 1'b1;
            count_nxt = (mode == MODE_SAT) ? MAX_VAL : '0;
         end else begin
            count_nxt = count + WIDTH'(1);
         end
      end else if (step_dn) begin
         if (count == '0) begin
            unf_hit   = 1'b1;
            tc_nxt    = 1'b1;
            count_nxt = (mode == MODE_SAT) ? '0 : MAX_VAL;
         end else begin
            count_nxt = count - WIDTH'(1);
         end
      end
   end

   // Count, pulse and sticky flags; a new event beats a simultaneous clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
         tc    <= 1'b0;
         ovf   <= 1'b0;
         unf   <= 1'b0;
      end else begin
         count <= count_nxt;
         tc    <= tc_nxt;
         ovf   <= ovf_hit | (ovf & ~clr_flags);
         unf   <= unf_hit | (unf & ~clr_flags);
      end
   end

   assign zero = (count == '0);

endmodule

// File: tb/tb_counter_ud_param.sv
// Bench for counter_ud_param: two instances (PRESCALE=1 and PRESCALE=4,
// both WIDTH=7, MAX_VAL=99) share one set of inputs. A behavioural model
// pushes expected outputs into a queue before each edge; they are popped
// and compared one time unit after the edge.
module tb_counter_ud_param;

   localparam int MAXV = 99;

   logic       clk = 1'b0;
   logic       rst, en, inc, dec, load, sat_mode, clr_flags;
   logic [6:0] load_val;

   logic [6:0] count_a, count_b;
   logic       tc_a, zero_a, ovf_a, unf_a;
   logic       tc_b, zero_b, ovf_b, unf_b;

   typedef struct {
      logic [6:0] count;
      logic       tc;
      logic       zero;
      logic       ovf;
      logic       unf;
   } exp_t;

   exp_t exp_q[$];

   int m_count[2];
   int m_phase[2];
   bit m_tc[2];
   bit m_ovf[2];
   bit m_unf[2];

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   counter_ud_param #(.WIDTH(7), .MAX_VAL(7'd99), .PRESCALE(1)) dut_a (
      .clk(clk), .rst(rst), .en(en), .inc(inc), .dec(dec), .load(load),
      .load_val(load_val), .sat_mode(sat_mode), .clr_flags(clr_flags),
      .count(count_a), .tc(tc_a), .zero(zero_a), .ovf(ovf_a), .unf(unf_a)
   );

   counter_ud_param #(.WIDTH(7), .MAX_VAL(7'd99), .PRESCALE(4)) dut_b (
      .clk(clk), .rst(rst), .en(en), .inc(inc), .dec(dec), .load(load),
      .load_val(load_val), .sat_mode(sat_mode), .clr_flags(clr_flags),
      .count(count_b), .tc(tc_b), .zero(zero_b), .ovf(ovf_b), .unf(unf_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance the model for instance k using the inputs currently driven.
   task automatic model_step(input int k);
      int p;
      bit tk, ov, un;
      p = (k == 0) ? 1 : 4;
      if (rst) begin
         m_count[k] = 0; m_phase[k] = 0;
         m_tc[k] = 0; m_ovf[k] = 0; m_unf[k] = 0;
      end else begin
         tk = en && (m_phase[k] == p - 1);
         ov = 0; un = 0;
         m_tc[k] = 0;
         if (load) begin
            m_count[k] = (int'(load_val) > MAXV) ? MAXV : int'(load_val);
         end else if (tk && inc && !dec) begin
            if (m_count[k] == MAXV) begin
               ov = 1; m_tc[k] = 1;
               m_count[k] = sat_mode ? MAXV : 0;
            end else begin
               m_count[k] = m_count[k] + 1;
            end
         end else if (tk && dec && !inc) begin
            if (m_count[k] == 0) begin
               un = 1; m_tc[k] = 1;
               m_count[k] = sat_mode ? 0 : MAXV;
            end else begin
               m_count[k] = m_count[k] - 1;
            end
         end
         m_ovf[k] = ov || (m_ovf[k] && !clr_flags);
         m_unf[k] = un || (m_unf[k] && !clr_flags);
         if (load)    m_phase[k] = 0;
         else if (en) m_phase[k] = (m_phase[k] + 1) % p;
      end
      exp_q.push_back('{count: 7'(m_count[k]), tc: m_tc[k], zero: (m_count[k] == 0),
                        ovf: m_ovf[k], unf: m_unf[k]});
   endtask

   // Run n clock cycles, scoring both instances after every edge.
   task automatic cyc(input int n = 1);
      exp_t e;
      repeat (n) begin
         model_step(0);
         model_step(1);
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         chk("a.count", 32'(count_a), 32'(e.count));
         chk("a.tc",    32'(tc_a),    32'(e.tc));
         chk("a.zero",  32'(zero_a),  32'(e.zero));
         chk("a.ovf",   32'(ovf_a),   32'(e.ovf));
         chk("a.unf",   32'(unf_a),   32'(e.unf));
         e = exp_q.pop_front();
         chk("b.count", 32'(count_b), 32'(e.count));
         chk("b.tc",    32'(tc_b),    32'(e.tc));
         chk("b.zero",  32'(zero_b),  32'(e.zero));
         chk("b.ovf",   32'(ovf_b),   32'(e.ovf));
         chk("b.unf",   32'(unf_b),   32'(e.unf));
      end
   endtask

   initial begin
      rst = 1; en = 0; inc = 0; dec = 0; load = 0; sat_mode = 0;
      clr_flags = 0; load_val = '0;

      // Reset state
      cyc(2);
      chk("rst.count_a", 32'(count_a), 0);
      chk("rst.zero_a",  32'(zero_a),  1);
      chk("rst.count_b", 32'(count_b), 0);

      // 100 up steps with wrap: 0..99 then 0, one tc pulse, ovf set
      rst = 0; en = 1; inc = 1;
      cyc(99);
      chk("up99.count", 32'(count_a), 99);
      chk("up99.tc",    32'(tc_a),    0);
      cyc(1);
      chk("wrap.count", 32'(count_a), 0);
      chk("wrap.tc",    32'(tc_a),    1);
      chk("wrap.ovf",   32'(ovf_a),   1);
      chk("b25.count",  32'(count_b), 25);
      inc = 0;
      cyc(1);
      chk("wrap.tc_off", 32'(tc_a),  0);
      chk("wrap.ovf_st", 32'(ovf_a), 1);

      // Clear racing a new wrap: event wins; clear alone then clears
      clr_flags = 1;
      cyc(1);
      chk("clr.ovf", 32'(ovf_a), 0);
      clr_flags = 0; load = 1; load_val = 7'd99;
      cyc(1);
      load = 0; inc = 1; clr_flags = 1;
      cyc(1);
      chk("race.count", 32'(count_a), 0);
      chk("race.ovf",   32'(ovf_a),   1);
      inc = 0;
      cyc(1);
      chk("clr2.ovf", 32'(ovf_a), 0);
      clr_flags = 0;

      // Down at 0 in wrap mode lands on MAX_VAL
      dec = 1;
      cyc(1);
      chk("dnwrap.count", 32'(count_a), 99);
      chk("dnwrap.unf",   32'(unf_a),   1);
      chk("dnwrap.tc",    32'(tc_a),    1);
      dec = 0; clr_flags = 1;
      cyc(1);
      clr_flags = 0;

      // Saturating down at 0 for 3 attempts
      load = 1; load_val = 7'd0;
      cyc(1);
      load = 0; sat_mode = 1; dec = 1;
      for (int i = 0; i < 3; i++) begin
         cyc(1);
         chk("sat.count", 32'(count_a), 0);
         chk("sat.unf",   32'(unf_a),   1);
         chk("sat.tc",    32'(tc_a),    1);
      end
      dec = 0;
      cyc(1);
      chk("sat.tc_off", 32'(tc_a), 0);

      // Load above MAX_VAL clips; inc+dec together holds
      load = 1; load_val = 7'd120;
      cyc(1);
      chk("ld120.count_a", 32'(count_a), 99);
      chk("ld120.count_b", 32'(count_b), 99);
      load = 0; inc = 1; dec = 1;
      cyc(4);
      chk("both.count_a", 32'(count_a), 99);
      chk("both.count_b", 32'(count_b), 99);
      chk("both.tc_a",    32'(tc_a),    0);
      inc = 0; dec = 0;

      // PRESCALE=4 with en dropped for 2 cycles
      load = 1; load_val = 7'd0;
      cyc(1);
      load = 0; inc = 1; en = 1;
      cyc(2);
      chk("ps.e2", 32'(count_b), 0);
      en = 0;
      cyc(2);
      chk("ps.dis", 32'(count_b), 0);
      en = 1;
      cyc(1);
      chk("ps.e3", 32'(count_b), 0);
      cyc(1);
      chk("ps.e4", 32'(count_b), 1);
      cyc(3);
      chk("ps.e7", 32'(count_b), 1);
      cyc(1);
      chk("ps.e8", 32'(count_b), 2);

      // Reset mid-prescale at count 57, overriding load
      load = 1; load_val = 7'd57; inc = 0;
      cyc(1);
      load = 0; inc = 1;
      cyc(2);
      chk("pre_rst.count_b", 32'(count_b), 57);
      rst = 1; load = 1; load_val = 7'd33;
      cyc(1);
      chk("mid_rst.count_b", 32'(count_b), 0);
      chk("mid_rst.ovf_b",   32'(ovf_b),   0);
      chk("mid_rst.unf_b",   32'(unf_b),   0);
      chk("mid_rst.zero_b",  32'(zero_b),  1);
      rst = 0; load = 0;
      cyc(3);
      chk("post_rst.e3", 32'(count_b), 0);
      cyc(1);
      chk("post_rst.e4", 32'(count_b), 1);

      // Mixed random traffic, scored by the model
      for (int i = 0; i < 80; i++) begin
         rst       = ($urandom_range(0, 31) == 0);
         load      = ($urandom_range(0, 7) == 0);
         en        = ($urandom_range(0, 3) != 0);
         inc       = $urandom_range(0, 1);
         dec       = $urandom_range(0, 1);
         sat_mode  = $urandom_range(0, 1);
         clr_flags = ($urandom_range(0, 7) == 0);
         load_val  = 7'($urandom_range(0, 127));
         cyc(1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
